// File: rtl/uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_stream
// Description : UART transmitter with a DEPTH-entry TX FIFO behind a
//               valid/ready byte input. Runtime baud divisor and 1/2 stop
//               bits, back-to-back frames with no idle gap.
//               Optional parity generation when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_stream #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CNT_W-1:0]         cfg_cpb_i,
  input  logic                     cfg_stop2_i,
  input  logic                     cfg_par_en_i,
  input  logic                     cfg_par_odd_i,
  input  logic                     tx_valid_i,
  input  logic [DATA_W-1:0]        tx_data_i,
  output logic                     tx_ready_o,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [AW:0]       LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers (extra MSB separates full from empty)
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  // Frame engine state
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;      // set while in the second stop bit
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cpb_q, cpb_d;        // latched effective clocks per bit
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;

  logic [AW:0]       level;
  logic              empty, full, push, pop, load, bit_end, done;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  cpb_eff;

  // FIFO status and handshake
  always_comb begin
    level   = wr_ptr_q - rd_ptr_q;
    full    = (level == LVL_FULL);
    empty   = (level == '0);
    push    = tx_valid_i & ~full;
    head    = mem_q[rd_ptr_q[AW-1:0]];
    bit_end = (cnt_q == cpb_q - CNT_ONE);
    cpb_eff = (cfg_cpb_i == '0) ? CNT_ONE : cfg_cpb_i;
  end

  // FIFO write and pointer advance
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = tx_data_i;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d, par_bit_q, par_bit_d;

  // Parity mode and bit are captured with the byte at frame load
  always_comb begin
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (load) begin
      par_en_d  = cfg_par_en_i;
      par_bit_d = (^head) ^ cfg_par_odd_i;
    end
  end

  // Parity registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end
`else
  logic unused_cfg_par;
  assign unused_cfg_par = cfg_par_en_i ^ cfg_par_odd_i;
`endif

  // Frame sequencing: next state, bit timing, serial bit selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    cpb_d   = cpb_q;
    stop2_d = stop2_q;
    tx_d    = tx_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
`else
            state_d = ST_STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IDX_ONE;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          cnt_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            done = 1'b1;
            if (!empty) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Frame start: pop head byte, snapshot configuration, drive start bit
    if (load) begin
      state_d = ST_START;
      cnt_d   = '0;
      idx_d   = '0;
      stop_d  = 1'b0;
      shift_d = head;
      cpb_d   = cpb_eff;
      stop2_d = cfg_stop2_i;
      tx_d    = 1'b0;
    end
  end

  assign pop = load;

  // Storage needs no reset: the pointers define which entries are valid
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      cpb_q    <= CNT_ONE;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      cpb_q    <= cpb_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
    end
  end

  assign tx_ready_o = ~full;
  assign tx_o       = tx_q;
  assign done_o     = done;
  assign level_o    = level;
  assign busy_o     = (state_q != ST_IDLE) | ~empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_stream
// Description : Self-checking bench for uart_tx_stream. A frame-level model
//               (byte queue plus expected per-cycle line samples) predicts
//               tx_o, done_o, level_o, tx_ready_o and busy_o every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic              clk, rst;
  logic [CNT_W-1:0]  cfg_cpb;
  logic              cfg_stop2, cfg_par_en, cfg_par_odd;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready_o, tx_o, busy_o, done_o;
  logic [$clog2(DEPTH):0] level_o;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [DATA_W-1:0] fifo_q[$];
  bit                wave_q[$];

  uart_tx_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_cpb_i(cfg_cpb), .cfg_stop2_i(cfg_stop2),
    .cfg_par_en_i(cfg_par_en), .cfg_par_odd_i(cfg_par_odd),
    .tx_valid_i(tx_valid), .tx_data_i(tx_data),
    .tx_ready_o(tx_ready_o), .tx_o(tx_o), .busy_o(busy_o),
    .done_o(done_o), .level_o(level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line samples of one whole frame from the current cfg inputs
  task automatic build_frame(input logic [DATA_W-1:0] d);
    int n;
    bit bits[$];
    n = (cfg_cpb == 0) ? 1 : int'(cfg_cpb);
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    if (cfg_par_en)
      bits.push_back(cfg_par_odd ? (($countones(d) % 2) == 0) : (($countones(d) % 2) == 1));
`endif
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    foreach (bits[b]) repeat (n) wave_q.push_back(bits[b]);
  endtask

  // Advance the model across one clock edge using the pre-edge inputs
  task automatic model_step();
    int pre_n;
    pre_n = fifo_q.size();
    if (rst) begin
      fifo_q.delete();
      wave_q.delete();
    end else begin
      if (wave_q.size() <= 1) begin
        if (wave_q.size() == 1) void'(wave_q.pop_front());
        if (pre_n > 0) build_frame(fifo_q.pop_front());
      end else begin
        void'(wave_q.pop_front());
      end
      if (tx_valid && pre_n < DEPTH) fifo_q.push_back(tx_data);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("tx_o",  {31'd0, tx_o},  {31'd0, (wave_q.size() != 0) ? wave_q[0] : 1'b1});
    chk("done_o", {31'd0, done_o}, {31'd0, wave_q.size() == 1});
    chk("level_o", 32'(level_o), 32'(fifo_q.size()));
    chk("tx_ready_o", {31'd0, tx_ready_o}, {31'd0, fifo_q.size() < DEPTH});
    chk("busy_o", {31'd0, busy_o}, {31'd0, (wave_q.size() != 0) || (fifo_q.size() != 0)});
    if (done_o === 1'b1) done_cnt++;
  endtask

  task automatic push1(input logic [DATA_W-1:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && busy_o; i++) tick();
    chk(tag, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    bit exp_pat[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    rst = 1'b1; cfg_cpb = 16'd4; cfg_stop2 = 1'b0; cfg_par_en = 1'b0;
    cfg_par_odd = 1'b0; tx_valid = 1'b0; tx_data = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("reset_tx", {31'd0, tx_o}, 32'd1);
    chk("reset_level", 32'(level_o), 32'd0);
    tick();

    // 0xA5 at cpb=4: fixed waveform and one done pulse on the last cycle
    done_cnt = 0;
    push1(8'hA5);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("a5_pattern", {31'd0, tx_o}, {31'd0, exp_pat[i / 4]});
      chk("a5_done", {31'd0, done_o}, {31'd0, i == 39});
    end
    repeat (5) tick();
    chk("a5_done_count", done_cnt, 1);

    // Three back-to-back frames at cpb=2
    cfg_cpb = 16'd2; done_cnt = 0;
    push1(8'h3C); push1(8'hC3); push1(8'h01);
    repeat (57) tick();
    chk("b2b_busy_contiguous", {31'd0, busy_o}, 32'd1);
    repeat (5) tick();
    chk("b2b_done_count", done_cnt, 3);
    drain("b2b_drain", 50);

    // Overflow: FSM stalled on a long bit, DEPTH+2 offered
    cfg_cpb = 16'd1000;
    tx_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      tx_data = 8'(i + 8'h10);
      tick();
    end
    tx_valid = 1'b0;
    chk("ovf_level", 32'(level_o), DEPTH);
    chk("ovf_ready", {31'd0, tx_ready_o}, 32'd0);
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // Parity and two stop bits
    cfg_cpb = 16'd2; cfg_par_en = 1'b1; cfg_par_odd = 1'b1; cfg_stop2 = 1'b1;
    push1(8'h03);
    drain("par_odd_drain", 100);
    cfg_par_odd = 1'b0;
    push1(8'h03);
    drain("par_even_drain", 100);
    cfg_par_en = 1'b0; cfg_stop2 = 1'b0;

    // Reset in the middle of DATA with a byte still queued
    cfg_cpb = 16'd3; done_cnt = 0;
    push1(8'h5A); push1(8'h77);
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_mid_level", 32'(level_o), 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_done_count", done_cnt, 0);
    tick();

    // cpb=0 and cpb=1 both one cycle per bit
    cfg_cpb = 16'd0; push1(8'h96); drain("cpb0_drain", 30);
    cfg_cpb = 16'd1; push1(8'h96); drain("cpb1_drain", 30);

    // cpb changed mid-frame keeps the running frame timing
    cfg_cpb = 16'd3; push1(8'hE1);
    repeat (5) tick();
    cfg_cpb = 16'd7;
    drain("cpb_change_drain", 200);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        cfg_cpb     = 16'($urandom_range(0, 3));
        cfg_stop2   = 1'($urandom_range(0, 1));
        cfg_par_en  = 1'($urandom_range(0, 1));
        cfg_par_odd = 1'($urandom_range(0, 1));
      end
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    drain("rand_drain", 3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
